muxdff_stage: RTL and testbench

- Single registered stage: a 2:1 mux feeding a D flip-flop.
- On each rising clock edge the register captures either the parallel-load value `r_in` (when `L`=1) or the chained/feedback value `q_in` (when `L`=0).
- Used as the building-block cell of loadable shift registers and LFSRs. `Q` of one stage drives `q_in` of the next stage or a feedback network.
- Parameterised width so one instance can serve as a multi-bit stage.

---
 rtl/muxdff_stage_if.sv | 26 ++
 rtl/muxdff_stage.sv | 36 +++
 tb/tb_muxdff_stage.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/muxdff_stage_if.sv
// Data-side bundle for one mux/flip-flop stage: load select, the two candidate
// inputs, and the registered output.
interface muxdff_stage_if #(
  parameter int WIDTH = 1
);
  logic             L;
  logic [WIDTH-1:0] r_in;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] Q;

  // No valid/ready: the stage samples L/r_in/q_in on every rising clk edge
  // and Q is valid one clock later, holding until the next edge.
  modport master (
    output L,
    output r_in,
    output q_in,
    input  Q
  );

  modport slave (
    input  L,
    input  r_in,
    input  q_in,
    output Q
  );
endinterface

// File: rtl/muxdff_stage.sv
// One loadable register stage: L selects r_in (parallel load) or q_in
// (shift/feedback) into a WIDTH-bit register that drives Q directly.
module muxdff_stage #(
  parameter int          WIDTH       = 1,
  parameter logic [63:0] RESET_VALUE = 64'd0
) (
  input  logic           clk,
  input  logic           reset,
  muxdff_stage_if.slave  bus
);

  localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] d_next;
  logic [WIDTH-1:0] q_reg;

  always_comb begin
    d_next = bus.q_in;
    if (bus.L) begin
      d_next = bus.r_in;
    end
  end

  // Reset wins over load; Q comes straight from the flop so chained stages
  // see the pre-edge value of their neighbour.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= RST_Q;
    end else begin
      q_reg <= d_next;
    end
  end

  assign bus.Q = q_reg;

endmodule

// File: tb/tb_muxdff_stage.sv
// Directed bench for muxdff_stage: a 1-bit stage, an 8-bit stage with a
// truncated reset value, and a 3-stage chain, checked against a scoreboard.
module tb_muxdff_stage;

  logic clk;
  logic reset;

  int checks;
  int errors;

  muxdff_stage_if #(.WIDTH(1)) main_if ();
  muxdff_stage_if #(.WIDTH(8)) w_if ();
  muxdff_stage_if #(.WIDTH(1)) c0_if ();
  muxdff_stage_if #(.WIDTH(1)) c1_if ();
  muxdff_stage_if #(.WIDTH(1)) c2_if ();

  muxdff_stage #(.WIDTH(1), .RESET_VALUE(64'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (main_if)
  );

  muxdff_stage #(.WIDTH(8), .RESET_VALUE(64'h1A5)) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (w_if)
  );

  muxdff_stage #(.WIDTH(1), .RESET_VALUE(64'd0)) dut_c0 (
    .clk   (clk),
    .reset (reset),
    .bus   (c0_if)
  );

  muxdff_stage #(.WIDTH(1), .RESET_VALUE(64'd0)) dut_c1 (
    .clk   (clk),
    .reset (reset),
    .bus   (c1_if)
  );

  muxdff_stage #(.WIDTH(1), .RESET_VALUE(64'd0)) dut_c2 (
    .clk   (clk),
    .reset (reset),
    .bus   (c2_if)
  );

  assign c1_if.q_in = c0_if.Q;
  assign c2_if.q_in = c1_if.Q;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  logic [7:0] exp_w_q[$];
  logic [2:0] exp_c_q[$];

  logic       m_q;
  logic [7:0] m_w;
  logic [2:0] m_c;
  logic       have_q;

  logic       chain_l;
  logic [2:0] chain_r;
  logic       chain_q0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of stimulus (just after an edge), pushes the expected
  // post-edge values, confirms Q is still steady mid-cycle, then checks.
  task automatic step(input string tag, input logic rs, input logic l,
                      input logic r, input logic q, input logic self_loop);
    logic       prev_q;
    logic [2:0] old_c;
    logic       w_l;
    logic [7:0] w_r;
    logic [7:0] w_q;
    logic [0:0] e1;
    logic [7:0] e8;
    logic [2:0] e3;

    prev_q = m_q;
    reset        = rs;
    main_if.L    = l;
    main_if.r_in = r;
    main_if.q_in = self_loop ? main_if.Q : q;

    w_l = 1'($urandom_range(0, 1));
    w_r = 8'($urandom_range(0, 255));
    w_q = 8'($urandom_range(0, 255));
    w_if.L    = w_l;
    w_if.r_in = w_r;
    w_if.q_in = w_q;

    c0_if.L    = chain_l;
    c1_if.L    = chain_l;
    c2_if.L    = chain_l;
    c0_if.r_in = chain_r[2];
    c1_if.r_in = chain_r[1];
    c2_if.r_in = chain_r[0];
    c0_if.q_in = chain_q0;

    m_q = rs ? 1'b0 : (l ? r : (self_loop ? m_q : q));
    m_w = rs ? 8'hA5 : (w_l ? w_r : w_q);
    old_c = m_c;
    if (rs) begin
      m_c = 3'b000;
    end else if (chain_l) begin
      m_c = chain_r;
    end else begin
      m_c = {chain_q0, old_c[2], old_c[1]};
    end
    exp_q.push_back(m_q);
    exp_w_q.push_back(m_w);
    exp_c_q.push_back(m_c);

    if (have_q) begin
      #2;
      chk({tag, "_hold"}, {7'd0, main_if.Q}, {7'd0, prev_q});
    end

    @(posedge clk);
    #1;
    e1 = exp_q.pop_front();
    e8 = exp_w_q.pop_front();
    e3 = exp_c_q.pop_front();
    chk(tag, {7'd0, main_if.Q}, {7'd0, e1});
    chk({tag, "_w"}, w_if.Q, e8);
    chk({tag, "_chain"}, {5'd0, c0_if.Q, c1_if.Q, c2_if.Q}, {5'd0, e3});
    have_q = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [2:0] combo;
    checks   = 0;
    errors   = 0;
    have_q   = 1'b0;
    m_q      = 1'b0;
    m_w      = 8'h00;
    m_c      = 3'b000;
    chain_l  = 1'b0;
    chain_r  = 3'b000;
    chain_q0 = 1'b0;

    // Reset beats load; then q_in=0 keeps Q at 0.
    step("reset_over_load", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("post_reset_shift0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Parallel load ignores q_in.
    step("load1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("load0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Shift ignores r_in.
    step("shift1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("shift0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Load a 1, then wiggle every input combination without an edge.
    step("load1_again", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      main_if.L    = combo[2];
      main_if.r_in = combo[1];
      main_if.q_in = combo[0];
      #1;
      chk("midcycle_toggle", {7'd0, main_if.Q}, 8'd1);
    end

    // Edge-by-edge sweep of {L, r_in, q_in}, with a low-phase hold check each.
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      step("sweep", 1'b0, combo[2], combo[1], combo[0], 1'b0);
    end

    // Reset in the middle of operation, then recovery.
    step("load_before_reset", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("reset_mid", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("load_after_reset", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Self-loop holds a 1, then a 0.
    for (int i = 0; i < 3; i++) begin
      step("self_loop_1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    step("load0_for_loop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("self_loop_0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    end

    // Three-stage chain: load 101 then shift zeros in.
    chain_l  = 1'b1;
    chain_r  = 3'b101;
    chain_q0 = 1'b0;
    step("chain_load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chain_l  = 1'b0;
    chain_r  = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step("chain_shift", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Shift a 1 into the chain to show no bubble between stages.
    chain_q0 = 1'b1;
    step("chain_in1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chain_q0 = 1'b0;
    step("chain_in0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("chain_in0b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    if (exp_q.size() != 0 || exp_w_q.size() != 0 || exp_c_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left=%0d required=0",
               exp_q.size() + exp_w_q.size() + exp_c_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
